// File: rtl/lcd_pattern_sequencer_pkg.sv
// Shared definitions for the LCD test-pattern sequencer: panel geometry,
// colour widths, pattern codes and sequencer state encodings.
package lcd_pattern_sequencer_pkg;

    localparam int H_ACTIVE = 480;
    localparam int V_ACTIVE = 272;

    localparam int X_W   = 9;
    localparam int Y_W   = 9;
    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int PAT_W = 3;

    localparam logic [PAT_W-1:0] PAT_RED   = 3'd0;
    localparam logic [PAT_W-1:0] PAT_GREEN = 3'd1;
    localparam logic [PAT_W-1:0] PAT_BLUE  = 3'd2;
    localparam logic [PAT_W-1:0] PAT_WHITE = 3'd3;
    localparam logic [PAT_W-1:0] PAT_BARS  = 3'd4;
    localparam logic [PAT_W-1:0] PAT_CHECK = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb_t;

    // Pattern index after an advance, wrapping the last pattern back to 0.
    function automatic logic [PAT_W-1:0] next_pattern(input logic [PAT_W-1:0] cur,
                                                      input int num);
        return (int'(cur) >= num - 1) ? '0 : cur + 3'd1;
    endfunction

endpackage

// File: rtl/lcd_pattern_gen.sv
// Combinational colour lookup: maps the current pattern and pixel position
// to a full-scale RGB565 value.
module lcd_pattern_gen
    import lcd_pattern_sequencer_pkg::*;
(
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    output logic [R_W-1:0]   o_r,
    output logic [G_W-1:0]   o_g,
    output logic [B_W-1:0]   o_b
);

    logic [2:0] bar;
    logic       check_white;
    logic       unused_xy;

    // Eight 64-pixel bars; 16-pixel checker squares.
    assign bar         = i_x[8:6];
    assign check_white = i_x[4] ^ i_y[4];
    assign unused_xy   = ^{i_x[5], i_x[3:0], i_y[8:5], i_y[3:0]};

    always_comb begin
        o_r = '0;
        o_g = '0;
        o_b = '0;
        case (i_pattern)
            PAT_RED:   o_r = '1;
            PAT_GREEN: o_g = '1;
            PAT_BLUE:  o_b = '1;
            PAT_WHITE: begin
                o_r = '1;
                o_g = '1;
                o_b = '1;
            end
            PAT_BARS: begin
                o_r = {R_W{bar[2]}};
                o_g = {G_W{bar[1]}};
                o_b = {B_W{bar[0]}};
            end
            PAT_CHECK: begin
                if (check_white) begin
                    o_r = '1;
                    o_g = '1;
                    o_b = '1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_pattern_sequencer.sv
// Frame-level LCD test-pattern controller: power-up blanking, automatic and
// manual pattern stepping, and the registered DEN/RGB panel outputs.
module lcd_pattern_sequencer
    import lcd_pattern_sequencer_pkg::*;
#(
    parameter int BLANK_FRAMES       = 2,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int NUM_PATTERNS       = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_hde,
    input  logic             i_vde,
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    input  logic             i_hold,
    input  logic             i_next,
    output logic             o_den,
    output logic [R_W-1:0]   o_r,
    output logic [G_W-1:0]   o_g,
    output logic [B_W-1:0]   o_b,
    output logic [PAT_W-1:0] o_pattern,
    output logic             o_frame_tick
);

    localparam int CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam int BLK_W = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

    seq_state_e       state_q, state_d;
    logic             vde_q, vde_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [BLK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic             den_q, den_d;
    rgb_t             pix_q, pix_d;

    logic             show_en;
    logic             auto_en;
    logic             blank_en;
    logic             blank_last;
    logic             frame_cnt_last;
    logic             advance;
    rgb_t             gen_pix;

    lcd_pattern_gen u_gen (
        .i_pattern (pattern_q),
        .i_x       (i_x),
        .i_y       (i_y),
        .o_r       (gen_pix.r),
        .o_g       (gen_pix.g),
        .o_b       (gen_pix.b)
    );

    assign blank_last     = (blank_cnt_q == BLK_W'(BLANK_FRAMES - 1));
    assign frame_cnt_last = (frame_cnt_q == CNT_W'(FRAMES_PER_PATTERN - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tick_q) begin
                    state_d = (BLANK_FRAMES == 0) ? ST_RUN : ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (tick_q && blank_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_hold) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!i_hold) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        show_en  = 1'b0;
        auto_en  = 1'b0;
        blank_en = 1'b0;
        case (state_q)
            ST_BLANK: blank_en = 1'b1;
            ST_RUN: begin
                show_en = 1'b1;
                auto_en = 1'b1;
            end
            ST_HOLD: show_en = 1'b1;
            default: ;
        endcase
    end

    // All pattern and counter updates happen on the registered frame tick, which
    // falls in vertical blanking, so the index never moves inside an active frame.
    always_comb begin
        vde_d       = i_vde;
        tick_d      = vde_q & ~i_vde;
        blank_cnt_d = blank_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pattern_d   = pattern_q;
        advance     = 1'b0;

        if (state_q == ST_IDLE) begin
            blank_cnt_d = '0;
        end

        if (tick_q) begin
            if (blank_en) begin
                blank_cnt_d = blank_cnt_q + 1'b1;
            end
            if (show_en && pending_q) begin
                advance     = 1'b1;
                frame_cnt_d = '0;
            end else if (auto_en) begin
                if (frame_cnt_last) begin
                    advance     = 1'b1;
                    frame_cnt_d = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end

        // A request arriving on the tick cycle itself survives to the next tick.
        pending_d = i_next | (pending_q & ~(tick_q & show_en));

        if (advance) begin
            pattern_d = next_pattern(pattern_q, NUM_PATTERNS);
        end

        den_d = show_en & i_hde & i_vde;
        pix_d = den_d ? gen_pix : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vde_q       <= 1'b0;
            tick_q      <= 1'b0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
            blank_cnt_q <= '0;
            pattern_q   <= '0;
            den_q       <= 1'b0;
            pix_q       <= '0;
        end else begin
            vde_q       <= vde_d;
            tick_q      <= tick_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            pattern_q   <= pattern_d;
            den_q       <= den_d;
            pix_q       <= pix_d;
        end
    end

    assign o_den        = den_q;
    assign o_r          = pix_q.r;
    assign o_g          = pix_q.g;
    assign o_b          = pix_q.b;
    assign o_pattern    = pattern_q;
    assign o_frame_tick = tick_q;

endmodule
